// File: rtl/disp_seq_pkg.sv
// Shared state encoding and defaults for the display sequencer.
// Pure declarations: no timing, no flow control.
package disp_seq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPIN     = 2'd1,
      ERR_OVER = 2'd2,
      ERR_CHG  = 2'd3
   } state_t;

   localparam logic [2:0] SEG_LAST = 3'd6;

   localparam int DEF_SPIN_DIV  = 2;
   localparam int DEF_SPIN_LAPS = 2;
   localparam int DEF_ERR_HOLD  = 4;

endpackage

// File: rtl/tick_hold_timer.sv
// Retriggerable hold timer counting tick_en pulses; load wins over a same-cycle tick.
// active is look-ahead: it reports whether the count after this cycle's update is nonzero.
module tick_hold_timer #(
   parameter int HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic tick_en,
   input  logic load,
   output logic active
);

   localparam int W = $clog2(HOLD + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(HOLD);
      end else if (tick_en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   // Look-ahead lets the owner register its flag in the same edge the count hits zero.
   assign active = load || (cnt > W'(1)) || ((cnt == W'(1)) && !tick_en);

endmodule

// File: rtl/display_sequencer.sv
// Sequences spin animation, error flags and view mode for one display bank.
// All outputs registered, one clk after the causing input; no backpressure (pulse inputs).
module display_sequencer
   import disp_seq_pkg::*;
#(
   parameter int SPIN_DIV  = DEF_SPIN_DIV,
   parameter int SPIN_LAPS = DEF_SPIN_LAPS,
   parameter int ERR_HOLD  = DEF_ERR_HOLD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_en,
   input  logic       start_req,
   input  logic       stop_req,
   input  logic       over_evt,
   input  logic       over_time_evt,
   input  logic       change_evt,
   input  logic       mode_btn,
   output logic [2:0] a2,
   output logic       signal,
   output logic       error_over_start,
   output logic       error_over_start_time,
   output logic       error_changing,
   output logic       mood,
   output logic       busy
);

   localparam int STEP_W = $clog2(SPIN_DIV + 1);
   localparam int LAP_W  = $clog2(SPIN_LAPS + 1);

   state_t            state;
   logic [STEP_W-1:0] step;
   logic [LAP_W-1:0]  lap;
   logic              err_load;
   logic              hold_active;
   logic              time_active;

   // change_evt cannot displace the higher-priority overflow display.
   assign err_load = over_evt || (change_evt && (state != ERR_OVER));

   tick_hold_timer #(.HOLD(ERR_HOLD)) u_main_hold (
      .clk     (clk),
      .reset   (reset),
      .tick_en (tick_en),
      .load    (err_load),
      .active  (hold_active)
   );

   tick_hold_timer #(.HOLD(ERR_HOLD)) u_time_hold (
      .clk     (clk),
      .reset   (reset),
      .tick_en (tick_en),
      .load    (over_time_evt),
      .active  (time_active)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                 <= IDLE;
         step                  <= '0;
         lap                   <= '0;
         a2                    <= '0;
         signal                <= 1'b0;
         error_over_start      <= 1'b0;
         error_over_start_time <= 1'b0;
         error_changing        <= 1'b0;
         mood                  <= 1'b0;
         busy                  <= 1'b0;
      end else begin
         mood                  <= mood ^ mode_btn;
         error_over_start_time <= time_active;

         if (over_evt) begin
            state            <= ERR_OVER;
            step             <= '0;
            lap              <= '0;
            a2               <= '0;
            signal           <= 1'b0;
            error_over_start <= 1'b1;
            error_changing   <= 1'b0;
            busy             <= 1'b1;
         end else if (change_evt && (state != ERR_OVER)) begin
            state            <= ERR_CHG;
            step             <= '0;
            lap              <= '0;
            a2               <= '0;
            signal           <= 1'b0;
            error_over_start <= 1'b0;
            error_changing   <= 1'b1;
            busy             <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start_req) begin
                     state  <= SPIN;
                     step   <= '0;
                     lap    <= '0;
                     a2     <= '0;
                     signal <= 1'b1;
                     busy   <= 1'b1;
                  end
               end
               SPIN: begin
                  if (stop_req) begin
                     state  <= IDLE;
                     step   <= '0;
                     lap    <= '0;
                     a2     <= '0;
                     signal <= 1'b0;
                     busy   <= 1'b0;
                  end else if (start_req) begin
                     step <= '0;
                     lap  <= '0;
                     a2   <= '0;
                  end else if (tick_en) begin
                     if (step == STEP_W'(SPIN_DIV - 1)) begin
                        step <= '0;
                        if (a2 == SEG_LAST) begin
                           a2 <= '0;
                           // Wrap that closes the final lap ends the animation.
                           if (lap == LAP_W'(SPIN_LAPS - 1)) begin
                              state  <= IDLE;
                              lap    <= '0;
                              signal <= 1'b0;
                              busy   <= 1'b0;
                           end else begin
                              lap <= lap + LAP_W'(1);
                           end
                        end else begin
                           a2 <= a2 + 3'd1;
                        end
                     end else begin
                        step <= step + STEP_W'(1);
                     end
                  end
               end
               ERR_OVER, ERR_CHG: begin
                  if (!hold_active) begin
                     state            <= IDLE;
                     error_over_start <= 1'b0;
                     error_changing   <= 1'b0;
                     busy             <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer with default parameters (SPIN_DIV=2, SPIN_LAPS=2, ERR_HOLD=4).
module tb_display_sequencer;

   logic       clk;
   logic       reset;
   logic       tick_en, start_req, stop_req, over_evt, over_time_evt, change_evt, mode_btn;
   logic [2:0] a2;
   logic       signal, error_over_start, error_over_start_time, error_changing, mood, busy;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] TK = 7'b1000000;
   localparam logic [6:0] ST = 7'b0100000;
   localparam logic [6:0] SP = 7'b0010000;
   localparam logic [6:0] OV = 7'b0001000;
   localparam logic [6:0] OT = 7'b0000100;
   localparam logic [6:0] CH = 7'b0000010;
   localparam logic [6:0] MB = 7'b0000001;

   display_sequencer dut (
      .clk                   (clk),
      .reset                 (reset),
      .tick_en               (tick_en),
      .start_req             (start_req),
      .stop_req              (stop_req),
      .over_evt              (over_evt),
      .over_time_evt         (over_time_evt),
      .change_evt            (change_evt),
      .mode_btn              (mode_btn),
      .a2                    (a2),
      .signal                (signal),
      .error_over_start      (error_over_start),
      .error_over_start_time (error_over_start_time),
      .error_changing        (error_changing),
      .mood                  (mood),
      .busy                  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs, then sample 1ns after the edge.
   task automatic drive(input logic [6:0] v);
      {tick_en, start_req, stop_req, over_evt, over_time_evt, change_evt, mode_btn} = v;
      @(posedge clk);
      #1;
      {tick_en, start_req, stop_req, over_evt, over_time_evt, change_evt, mode_btn} = '0;
   endtask

   task automatic test_reset;
      logic [7:0] got;
      got = {a2, signal, error_over_start, error_over_start_time, error_changing, mood, busy};
      total++;
      if (got !== 8'h00) begin
         bad++;
         $display("FAIL reset_state: got %h want 00", got);
      end
   endtask

   task automatic test_spin_full;
      logic [2:0] exp_a2;
      logic       exp_sig;
      drive(ST);
      total++;
      if ({a2, signal, busy} !== {3'd0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL spin_start: got a2=%0d sig=%b busy=%b want 0 1 1", a2, signal, busy);
      end
      for (int k = 1; k <= 28; k++) begin
         drive(TK);
         exp_a2  = (k < 28) ? 3'((k / 2) % 7) : 3'd0;
         exp_sig = (k < 28);
         total++;
         if ({a2, signal, busy} !== {exp_a2, exp_sig, exp_sig}) begin
            bad++;
            $display("FAIL spin_tick%0d: got a2=%0d sig=%b busy=%b want %0d %b %b",
                     k, a2, signal, busy, exp_a2, exp_sig, exp_sig);
         end
      end
   endtask

   task automatic test_stop;
      drive(ST);
      for (int k = 0; k < 6; k++) drive(TK);
      total++;
      if (a2 !== 3'd3) begin
         bad++;
         $display("FAIL stop_pre_a2: got %0d want 3", a2);
      end
      drive(SP);
      total++;
      if ({a2, signal, busy} !== {3'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL stop_idle: got a2=%0d sig=%b busy=%b want 0 0 0", a2, signal, busy);
      end
      drive(ST);
      drive(TK);
      drive(TK);
      total++;
      if ({a2, signal} !== {3'd1, 1'b1}) begin
         bad++;
         $display("FAIL stop_restart: got a2=%0d sig=%b want 1 1", a2, signal);
      end
      drive(SP);
   endtask

   task automatic test_back_to_back;
      drive(ST);
      for (int k = 0; k < 5; k++) drive(TK);
      drive(ST);
      total++;
      if ({a2, signal} !== {3'd0, 1'b1}) begin
         bad++;
         $display("FAIL restart_a2: got a2=%0d sig=%b want 0 1", a2, signal);
      end
      drive(TK);
      drive(TK);
      total++;
      if (a2 !== 3'd1) begin
         bad++;
         $display("FAIL restart_step: got %0d want 1", a2);
      end
      // Restart coinciding with a tick: that tick must not count.
      drive(TK | ST);
      drive(TK);
      total++;
      if (a2 !== 3'd0) begin
         bad++;
         $display("FAIL restart_tick_dropped: got %0d want 0", a2);
      end
      drive(TK);
      total++;
      if (a2 !== 3'd1) begin
         bad++;
         $display("FAIL restart_tick_next: got %0d want 1", a2);
      end
      drive(SP);
   endtask

   task automatic test_retrigger;
      drive(ST);
      drive(TK);
      drive(OV);
      total++;
      if ({error_over_start, signal, busy} !== 3'b101) begin
         bad++;
         $display("FAIL over_entry: got eos=%b sig=%b busy=%b want 1 0 1", error_over_start, signal, busy);
      end
      drive(TK);
      drive(TK);
      drive(CH);
      total++;
      if ({error_over_start, error_changing} !== 2'b10) begin
         bad++;
         $display("FAIL chg_ignored: got eos=%b ech=%b want 1 0", error_over_start, error_changing);
      end
      drive(TK | OV);
      for (int k = 1; k <= 4; k++) begin
         drive(TK);
         total++;
         if ({error_over_start, busy} !== {(k < 4), (k < 4)}) begin
            bad++;
            $display("FAIL retrig_tick%0d: got eos=%b busy=%b want %b", k, error_over_start, busy, (k < 4));
         end
      end
   endtask

   task automatic test_priority;
      drive(OV | CH | ST);
      total++;
      if ({error_over_start, error_changing, signal} !== 3'b100) begin
         bad++;
         $display("FAIL prio_entry: got eos=%b ech=%b sig=%b want 1 0 0", error_over_start, error_changing, signal);
      end
      for (int k = 1; k <= 4; k++) begin
         drive(TK);
         total++;
         if ({error_over_start, error_changing} !== {(k < 4), 1'b0}) begin
            bad++;
            $display("FAIL prio_tick%0d: got eos=%b ech=%b want %b 0", k, error_over_start, error_changing, (k < 4));
         end
      end
   endtask

   task automatic test_time_path;
      logic [2:0] exp;
      drive(CH);
      drive(TK);
      drive(TK);
      drive(OT);
      total++;
      if ({error_changing, error_over_start_time} !== 2'b11) begin
         bad++;
         $display("FAIL time_both: got ech=%b eost=%b want 1 1", error_changing, error_over_start_time);
      end
      for (int k = 1; k <= 4; k++) begin
         drive(TK);
         exp = {(k < 2), (k < 2), (k < 4)};
         total++;
         if ({error_changing, busy, error_over_start_time} !== exp) begin
            bad++;
            $display("FAIL time_tick%0d: got ech=%b busy=%b eost=%b want %b",
                     k, error_changing, busy, error_over_start_time, exp);
         end
      end
   endtask

   task automatic test_mode;
      for (int k = 1; k <= 3; k++) begin
         drive(MB);
         total++;
         if ({mood, busy, signal} !== {logic'(k % 2), 2'b00}) begin
            bad++;
            $display("FAIL mode_press%0d: got mood=%b busy=%b sig=%b want %0d 0 0", k, mood, busy, signal, k % 2);
         end
      end
   endtask

   task automatic test_reset_mid_spin;
      logic [7:0] got;
      drive(ST);
      for (int k = 0; k < 8; k++) drive(TK);
      total++;
      if (a2 !== 3'd4) begin
         bad++;
         $display("FAIL rst_pre_a2: got %0d want 4", a2);
      end
      reset = 1'b0;
      #2;
      got = {a2, signal, error_over_start, error_over_start_time, error_changing, mood, busy};
      total++;
      if (got !== 8'h00) begin
         bad++;
         $display("FAIL rst_async: got %h want 00", got);
      end
      reset = 1'b1;
      drive(TK);
      total++;
      if ({a2, busy, signal} !== 5'b0) begin
         bad++;
         $display("FAIL rst_release: got a2=%0d busy=%b sig=%b want 0 0 0", a2, busy, signal);
      end
   endtask

   initial begin
      reset = 1'b0;
      {tick_en, start_req, stop_req, over_evt, over_time_evt, change_evt, mode_btn} = '0;
      #12;
      test_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      test_spin_full();
      test_stop();
      test_back_to_back();
      test_retrigger();
      test_priority();
      test_time_path();
      test_mode();
      test_reset_mid_spin();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
